// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: rebuilds hex digits from a time-multiplexed seven-segment bus
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   an                  one-hot digit enables (an[i] selects digit i)
//   a..g, dot           segment lines and decimal point, active-high
//   hex_out             published frame, digit i at hex_out[4i+3:4i]
//   dots_out            published dot per digit
//   digit_bad           per-digit illegal-glyph flag of the published frame
//   err                 OR of digit_bad
//   valid               one-cycle pulse when the outputs update
module seg7_scan_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic                    a,
  input  logic                    b,
  input  logic                    c,
  input  logic                    d,
  input  logic                    e,
  input  logic                    f,
  input  logic                    g,
  input  logic                    dot,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   dots_out,
  output logic [NUM_DIGITS-1:0]   digit_bad,
  output logic                    err,
  output logic                    valid
);
  localparam int W = NUM_DIGITS + 8;
  // counter value seen on the edge sampling the STABLE_CYCLES-th identical word
  localparam logic [7:0] FIRE_AT = 8'(STABLE_CYCLES - 2);

  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1111110: decode = 5'h00;
      7'b0110000: decode = 5'h01;
      7'b1101101: decode = 5'h02;
      7'b1111001: decode = 5'h03;
      7'b0110011: decode = 5'h04;
      7'b1011011: decode = 5'h05;
      7'b1011111: decode = 5'h06;
      7'b1110000: decode = 5'h07;
      7'b1111111: decode = 5'h08;
      7'b1111011: decode = 5'h09;
      7'b1110111: decode = 5'h0a;
      7'b0011111: decode = 5'h0b;
      7'b1001110: decode = 5'h0c;
      7'b0111101: decode = 5'h0d;
      7'b1001111: decode = 5'h0e;
      7'b1000111: decode = 5'h0f;
      default:    decode = 5'h10;
    endcase
  endfunction

  logic [W-1:0]            word, prev_q;
  logic [7:0]              cnt_q, cnt_d;
  logic                    cap_q, cap_d, pub_q, pub_d;
  logic                    onehot, same, fire;
  logic [4:0]              dv;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d, sh_dot_q, sh_bad_q, dots_q, bad_q;
  logic [4*NUM_DIGITS-1:0] sh_hex_q, hex_q;

  always_comb begin
    word   = {an, a, b, c, d, e, f, g, dot};
    onehot = (an != '0) && ((an & (an - 1'b1)) == '0);
    same   = onehot && (word == prev_q);
    fire   = same && !cap_q && (cnt_q == FIRE_AT);
    cnt_d  = same ? ((cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1) : 8'd0;
    cap_d  = same && (cap_q || fire);
    dv     = decode({a, b, c, d, e, f, g});
    seen_d = (pub_q ? '0 : seen_q) | (fire ? an : '0);
    pub_d  = fire && (&seen_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q   <= '0;
      cnt_q    <= '0;
      cap_q    <= 1'b0;
      pub_q    <= 1'b0;
      seen_q   <= '0;
      sh_hex_q <= '0;
      sh_dot_q <= '0;
      sh_bad_q <= '0;
      hex_q    <= '0;
      dots_q   <= '0;
      bad_q    <= '0;
      valid    <= 1'b0;
    end else begin
      prev_q <= word;
      cnt_q  <= cnt_d;
      cap_q  <= cap_d;
      pub_q  <= pub_d;
      seen_q <= seen_d;
      valid  <= pub_q;
      for (int i = 0; i < NUM_DIGITS; i++)
        if (fire && an[i]) begin
          sh_hex_q[4*i+:4] <= dv[3:0];
          sh_dot_q[i]      <= dot;
          sh_bad_q[i]      <= dv[4];
        end
      if (pub_q) begin
        hex_q  <= sh_hex_q;
        dots_q <= sh_dot_q;
        bad_q  <= sh_bad_q;
      end
    end
  end

  assign hex_out   = hex_q;
  assign dots_out  = dots_q;
  assign digit_bad = bad_q;
  assign err       = |bad_q;
endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: scoreboard bench for seg7_scan_reader
module tb_seg7_scan_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  an = '0;
  logic        a, b, c, d, e, f, g, dot;
  logic [15:0] hex_out;
  logic [3:0]  dots_out, digit_bad;
  logic        err, valid;

  typedef struct packed {
    logic [15:0] h;
    logic [3:0]  dt;
    logic [3:0]  bd;
    logic        er;
  } exp_t;

  exp_t q[$];
  int   ncmp = 0;
  int   nerr = 0;
  logic prev_valid = 1'b0;
  logic [6:0] glyph [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                             7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  seg7_scan_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .an(an), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .dot(dot), .hex_out(hex_out), .dots_out(dots_out), .digit_bad(digit_bad),
    .err(err), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic hold(input logic [3:0] en, input logic [6:0] s, input logic dp, input int n);
    an = en;
    {a, b, c, d, e, f, g} = s;
    dot = dp;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [15:0] hx, input logic [3:0] dt);
    q.push_back('{hx, dt, 4'b0000, 1'b0});
    for (int i = 0; i < 4; i++) begin
      logic [3:0] nib;
      nib = hx[4*i+:4];
      hold(4'b0001 << i, glyph[nib], dt[i], 5);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (valid && prev_valid) chk("valid_double", 1, 0);
        if (valid) begin
          if (q.size() == 0) chk("unexpected_valid", 1, 0);
          else begin
            exp_t x;
            x = q.pop_front();
            chk("hex_out", 32'(hex_out), 32'(x.h));
            chk("dots_out", 32'(dots_out), 32'(x.dt));
            chk("digit_bad", 32'(digit_bad), 32'(x.bd));
            chk("err", 32'(err), 32'(x.er));
          end
        end
        prev_valid = valid;
      end else prev_valid = 1'b0;
    end
  end

  initial begin
    hold(4'b0000, 7'b0, 1'b0, 2);
    chk("rst_hex", 32'(hex_out), 0);
    chk("rst_valid", 32'(valid), 0);
    rst = 1'b0;
    hold(4'b0000, 7'b0, 1'b0, 3);
    frame(16'h4321, 4'b0000);
    hold(4'b0001, glyph[5], 1'b1, 5);
    hold(4'b0010, glyph[7], 1'b0, 2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_hex", 32'(hex_out), 0);
    chk("mid_rst_dots", 32'(dots_out), 0);
    chk("mid_rst_bad", 32'(digit_bad), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_valid", 32'(valid), 0);
    @(negedge clk) rst = 1'b0;
    hold(4'b0010, glyph[7], 1'b0, 5);
    hold(4'b0100, glyph[8], 1'b0, 5);
    hold(4'b1000, glyph[9], 1'b1, 8);
    q.push_back('{16'h9876, 4'b1000, 4'b0000, 1'b0});
    hold(4'b0001, glyph[6], 1'b0, 5);
    q.push_back('{16'h4329, 4'b0000, 4'b0000, 1'b0});
    hold(4'b0001, glyph[8], 1'b0, 3);
    hold(4'b0001, glyph[9], 1'b0, 5);
    hold(4'b0010, glyph[2], 1'b0, 5);
    hold(4'b0100, glyph[3], 1'b0, 5);
    hold(4'b1000, glyph[4], 1'b0, 5);
    q.push_back('{16'h4021, 4'b0100, 4'b0100, 1'b1});
    hold(4'b0001, glyph[1], 1'b0, 5);
    hold(4'b0010, glyph[2], 1'b0, 5);
    hold(4'b0100, 7'b1010101, 1'b1, 5);
    hold(4'b1000, glyph[4], 1'b0, 5);
    q.push_back('{16'hCDAB, 4'b0010, 4'b0000, 1'b0});
    hold(4'b0001, glyph[11], 1'b0, 5);
    hold(4'b0010, glyph[10], 1'b1, 5);
    hold(4'b0011, glyph[5], 1'b0, 20);
    hold(4'b0000, glyph[5], 1'b0, 20);
    hold(4'b0100, glyph[13], 1'b0, 5);
    hold(4'b1000, glyph[12], 1'b0, 5);
    frame(16'h3210, 4'b0101);
    frame(16'h7654, 4'b1010);
    frame(16'hBA98, 4'b0011);
    frame(16'hFEDC, 4'b1100);
    hold(4'b0000, 7'b0, 1'b0, 10);
    chk("queue_drained", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Receiving end of the team's seven-segment display path. It samples a time-multiplexed display bus (one-hot digit enables plus segment lines a–g and dot) and rebuilds each displayed digit as a hex nibble. A digit is captured only after its pattern has been stable for a programmable dwell. The block then publishes a complete frame with a one-cycle valid pulse and flags any segment pattern that is not a legal hex glyph. It sits in monitors and loopback benches, opposite the hex-to-7-segment decoder.

## Interface

- NUM_DIGITS, 4, number of multiplexed digits (1–8).
- STABLE_CYCLES, 4, consecutive identical samples required before a capture (2–255).
- clk  in  1  rising-edge system clock; all inputs synchronous to it, no synchronizer inside.
- rst  in  1  reset, asynchronous and active-high.
- an  in  NUM_DIGITS  digit enable, active-high; an[i] selects digit i.
- a, b, c, d, e, f, g  in  1 each  segment lines, active-high (1 = lit).
- dot  in  1  decimal point, active-high.
- hex_out  out  4*NUM_DIGITS  frame result; digit i at hex_out[4i+3:4i].
- dots_out  out  NUM_DIGITS  dot state per digit.
- digit_bad  out  NUM_DIGITS  per-digit illegal-glyph flag for the published frame.
- err  out  1  OR of digit_bad for the published frame.
- valid  out  1  one-cycle pulse when hex_out, dots_out, digit_bad and err update.

## Operation

- Glyph table, written as {a,b,c,d,e,f,g}:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001
  - 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000
  - 8 = 1111111, 9 = 1111011, A = 1110111, b = 0011111
  - C = 1001110, d = 0111101, E = 1001111, F = 1000111
- Any other pattern is illegal: nibble stored as 0, bad bit set.
- Sample word is {an, a..g, dot}. It is registered every cycle as prev.
- Stability counter:
  - Increments (saturating) when the current word equals prev and an is one-hot.
  - Otherwise it is cleared to 0, and the dwell's captured flag is cleared.
- Capture:
  - Fires once per dwell, on the edge where the same one-hot word has been sampled STABLE_CYCLES consecutive times.
  - Writes the nibble, dot and bad bit into shadow slot i and sets seen[i].
  - A digit recaptured before the frame completes overwrites its slot.
  - Holding a word past capture causes no further captures.
- Frame completion:
  - Occurs when seen is all ones after a capture.
  - On the following edge, the shadow is copied to hex_out, dots_out and digit_bad; err = |digit_bad; valid = 1; seen clears.
  - Outputs hold until the next frame completes.
- Words with an = 0 or multi-hot never capture and do not alter seen.

## Timing

- Reset values: hex_out 0, dots_out 0, digit_bad 0, err 0, valid 0. seen, shadow, counter, captured flag and prev are also 0.
- Capture latency: capture happens on the edge that samples the STABLE_CYCLES-th identical word.
- Publish latency: valid rises one cycle after the capture that completes the frame. valid is never high for two consecutive cycles.
- A word held for STABLE_CYCLES−1 samples and then changed is discarded with no state change.
- A change to the word and a capture cannot coincide; a changed word restarts the count.
- Reset asserted mid-frame clears all state immediately, asynchronously. The partial frame is lost. Counting restarts from the first post-reset sample.

## Test plan

- Reset check: assert rst mid-dwell on digit 1 → all outputs 0 immediately. After release, no valid until all 4 digits are captured anew.
- Nominal frame, STABLE_CYCLES=4:
  - Stimulus: hold an=0001/glyph 1, an=0010/glyph 2, an=0100/glyph 3, an=1000/glyph 4, 5 cycles each.
  - Response: one valid pulse one cycle after the 4th capture; hex_out=16'h4321, err=0, digit_bad=0000.
- Glitch rejection: hold digit 0 at glyph 8 for 3 cycles, then glyph 9 for 5 cycles, with the other digits normal → digit 0 nibble = 9, exactly one valid.
- Illegal glyph: digit 2 driven with 1010101, dot=1 → digit_bad=0100, err=1, hex_out[11:8]=0, dots_out=0100.
- Bad enables: an=0011 or an=0000 held 20 cycles → no capture, no valid, seen unchanged. A following legal frame publishes normally.
- Full decode sweep: four consecutive frames cover glyphs 0–F, with dot toggling per digit → every nibble and dot matches the driven value, err=0 throughout.
